// File: rtl/csr_file_pkg.sv
// Shared types for csr_file: request function codes, the CSR address map,
// counter selectors and the CSRRW/CSRRS/CSRRC write-value helper.
package csr_file_pkg;

    typedef enum logic [1:0] {
        RW   = 2'd0,
        RS   = 2'd1,
        RC   = 2'd2,
        NONE = 2'd3
    } funct_t;

    typedef enum logic [11:0] {
        CSR_CYCLE     = 12'hC00,
        CSR_TIME      = 12'hC01,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_TIMEH     = 12'hC81,
        CSR_INSTRETH  = 12'hC82,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82
    } csr_addr_t;

    localparam logic [11:0] SCRATCH_BASE = 12'h800;

    typedef enum logic [1:0] {
        CYCLE   = 2'd0,
        TIME    = 2'd1,
        INSTRET = 2'd2
    } ctr_sel_t;

    function automatic logic [63:0] csr_wval(input funct_t funct, input logic [63:0] old,
                                             input logic [63:0] wdata);
        case (funct)
            RW:      return wdata;
            RS:      return old | wdata;
            RC:      return old & ~wdata;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit wrapping counter with independently writable 32-bit halves.
// Any write in a cycle replaces the addressed half(s) and suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_value[31:0]  <= wdata;
            if (wr_hi) r_value[63:32] <= wdata;
        end else if (inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/csr_file.sv
// csr_file: cycle/time/instret counters plus NUM_SCRATCH scratch CSRs behind a one-cycle
// valid/ready CSR port. Define CSR_MCOUNTER_EN to add writable mcycle/minstret aliases.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_SCRATCH = 4,
    parameter int TIME_DIV    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  funct_t          req_funct,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            retire,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal
);

    localparam int NSCR = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam int SW   = (NSCR > 1) ? $clog2(NSCR) : 1;
    localparam int PW   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIME_DIV - 1);

    logic [XLEN-1:0] r_scratch [NSCR];
    logic [PW-1:0]   r_presc;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_illegal;

    logic [63:0]     w_cycle, w_time, w_instret, w_ctr_val, w_wdata64;
    logic [XLEN-1:0] w_old, w_new;
    logic [SW-1:0]   w_idx;
    ctr_sel_t        w_sel;
    logic w_accept, w_mapped, w_ro, w_is_scr, w_ctr_hit, w_hi;
    logic w_write_req, w_illegal, w_commit, w_ctr_wr, w_time_tick;

    assign req_ready   = !r_rsp_valid || rsp_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_wdata64   = 64'(req_wdata);
    assign w_idx       = req_addr[SW-1:0];
    assign w_time_tick = (r_presc == PRESC_MAX);

    always_comb begin
        w_mapped  = 1'b0;
        w_ro      = 1'b0;
        w_is_scr  = 1'b0;
        w_ctr_hit = 1'b0;
        w_hi      = req_addr[7];
        w_sel     = CYCLE;
        case (req_addr)
            CSR_CYCLE, CSR_CYCLEH:     begin w_mapped = 1'b1; w_ro = 1'b1; w_ctr_hit = 1'b1; w_sel = CYCLE;   end
            CSR_TIME, CSR_TIMEH:       begin w_mapped = 1'b1; w_ro = 1'b1; w_ctr_hit = 1'b1; w_sel = TIME;    end
            CSR_INSTRET, CSR_INSTRETH: begin w_mapped = 1'b1; w_ro = 1'b1; w_ctr_hit = 1'b1; w_sel = INSTRET; end
`ifdef CSR_MCOUNTER_EN
            CSR_MCYCLE, CSR_MCYCLEH:     begin w_mapped = 1'b1; w_ctr_hit = 1'b1; w_sel = CYCLE;   end
            CSR_MINSTRET, CSR_MINSTRETH: begin w_mapped = 1'b1; w_ctr_hit = 1'b1; w_sel = INSTRET; end
`endif
            default: begin
                if (req_addr[11:4] == SCRATCH_BASE[11:4] && int'(req_addr[3:0]) < NUM_SCRATCH) begin
                    w_mapped = 1'b1;
                    w_is_scr = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        case (w_sel)
            TIME:    w_ctr_val = w_time;
            INSTRET: w_ctr_val = w_instret;
            default: w_ctr_val = w_cycle;
        endcase
        w_old = '0;
        if (w_ctr_hit)
            w_old = w_hi ? XLEN'(w_ctr_val[63:32]) : XLEN'(w_ctr_val[31:0]);
        else if (w_is_scr)
            w_old = r_scratch[w_idx];
    end

    // RS/RC with a zero operand are pure reads, which keeps them legal on read-only counters.
    assign w_write_req = (req_funct == RW) || ((req_funct == RS || req_funct == RC) && w_wdata64 != 64'd0);
    assign w_illegal   = !w_mapped || (w_ro && w_write_req);
    assign w_commit    = w_accept && !w_illegal && w_write_req;
    assign w_ctr_wr    = w_commit && w_ctr_hit;
    assign w_new       = XLEN'(csr_wval(req_funct, 64'(w_old), w_wdata64));

    csr_counter64 u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (w_ctr_wr && w_sel == CYCLE && !w_hi),
        .wr_hi (w_ctr_wr && w_sel == CYCLE && w_hi),
        .wdata (w_new[31:0]),
        .value (w_cycle)
    );

    csr_counter64 u_time (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_time_tick),
        .wr_lo (1'b0),
        .wr_hi (1'b0),
        .wdata (32'd0),
        .value (w_time)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .wr_lo (w_ctr_wr && w_sel == INSTRET && !w_hi),
        .wr_hi (w_ctr_wr && w_sel == INSTRET && w_hi),
        .wdata (w_new[31:0]),
        .value (w_instret)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_time_tick ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSCR; i++) r_scratch[i] <= '0;
        end else if (w_commit && w_is_scr) begin
            r_scratch[w_idx] <= w_new;
        end
    end

    // Single response slot: a new accept overwrites it, otherwise it drains on rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= w_illegal ? '0 : w_old;
            r_rsp_illegal <= w_illegal;
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: table vectors, hand sequences and random accesses for csr_file, checked against
// an edge-count/array reference model. Honours CSR_MCOUNTER_EN like the design.
module tb_csr_file;
    import csr_file_pkg::*;

    localparam int XLEN        = 32;
    localparam int NUM_SCRATCH = 4;
    localparam int TIME_DIV    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    funct_t      req_funct = NONE;
    logic [31:0] req_wdata = '0;
    logic        retire = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    int vectors = 0;
    int miscompares = 0;
    longint unsigned edges = 0;
    longint unsigned instCount = 0;
    logic [31:0] scr [16];
    bit retireEn = 1'b0;

    typedef struct {
        logic [11:0] addr;
        funct_t      f;
        logic [31:0] wd;
        logic [31:0] expData;
        logic        expIll;
    } vec_t;

    csr_file #(.XLEN(XLEN), .NUM_SCRATCH(NUM_SCRATCH), .TIME_DIV(TIME_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_funct   (req_funct),
        .req_wdata   (req_wdata),
        .retire      (retire),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    // Reference time base: clock edges and retire pulses seen since reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges     <= 0;
            instCount <= 0;
        end else begin
            edges <= edges + 1;
            if (retire) instCount <= instCount + 1;
        end
    end

    always @(negedge clk) retire = retireEn ? 1'($urandom_range(0, 1)) : 1'b0;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected result of an access accepted at the next edge; also applies scratch writes.
    task automatic modelAccess(input logic [11:0] addr, input funct_t f, input logic [31:0] wd,
                               output logic [31:0] expData, output logic expIll);
        longint unsigned v;
        bit isCtr;
        bit wr;
        int idx;
        v = 0;
        isCtr = 1'b0;
        wr = (f == RW) || (f != NONE && wd != 0);
        expIll = 1'b1;
        expData = '0;
        case (addr)
            12'hC00, 12'hC80: begin v = edges;            isCtr = 1'b1; end
            12'hC01, 12'hC81: begin v = edges / TIME_DIV; isCtr = 1'b1; end
            12'hC02, 12'hC82: begin v = instCount;        isCtr = 1'b1; end
            default: ;
        endcase
        if (isCtr) begin
            expIll = wr;
            if (!wr) expData = addr[7] ? v[63:32] : v[31:0];
        end else if (addr >= 12'h800 && int'(addr) < 12'h800 + NUM_SCRATCH) begin
            idx = int'(addr) - 12'h800;
            expIll = 1'b0;
            expData = scr[idx];
            case (f)
                RW:      scr[idx] = wd;
                RS:      scr[idx] = scr[idx] | wd;
                RC:      scr[idx] = scr[idx] & ~wd;
                default: ;
            endcase
        end
    endtask

    // Called at a falling edge; returns the response captured at a later falling edge.
    task automatic applyStimulus(input logic [11:0] addr, input funct_t f, input logic [31:0] wd,
                                 output logic [31:0] rdata, output logic ill);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_funct = f;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) checkOutput("rsp timeout", 64'(rsp_valid), 64'd1);
        rdata = rsp_rdata;
        ill   = rsp_illegal;
    endtask

    task automatic modelCheck(input string name, input logic [11:0] addr, input funct_t f,
                              input logic [31:0] wd);
        logic [31:0] expData, rd;
        logic expIll, ill;
        modelAccess(addr, f, wd, expData, expIll);
        applyStimulus(addr, f, wd, rd, ill);
        checkOutput({name, " rdata"}, 64'(rd), 64'(expData));
        checkOutput({name, " illegal"}, 64'(ill), 64'(expIll));
    endtask

    initial begin
        vec_t tbl[$];
        logic [11:0] addrList[$];
        logic [31:0] rd, expData, wd;
        logic ill, expIll;
        funct_t f;

        foreach (scr[i]) scr[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("reset rsp_illegal", 64'(rsp_illegal), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'd1);

        repeat (10) @(negedge clk);
        applyStimulus(12'hC00, NONE, 32'd0, rd, ill);
        checkOutput("cycle after 10 clks", 64'(rd), 64'd10);
        checkOutput("cycle illegal", 64'(ill), 64'd0);
        modelCheck("cycleh", 12'hC80, NONE, 32'd0);
        retireEn = 1'b1;

        tbl.push_back('{12'h800, RW,   32'hA5A5_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'h800, RS,   32'h0000_00FF, 32'hA5A5_0000, 1'b0});
        tbl.push_back('{12'h800, RC,   32'hA500_0000, 32'hA5A5_00FF, 1'b0});
        tbl.push_back('{12'h800, NONE, 32'h0000_0000, 32'h00A5_00FF, 1'b0});
        tbl.push_back('{12'h804, NONE, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'h804, RW,   32'h1234_5678, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'h123, NONE, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'hC00, RW,   32'h0000_0005, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'hC81, RS,   32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{12'hC80, RC,   32'h0000_0001, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'h80F, RC,   32'h0000_0000, 32'h0000_0000, 1'b1});
`ifndef CSR_MCOUNTER_EN
        tbl.push_back('{12'hB00, NONE, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{12'hB82, RW,   32'h0000_0001, 32'h0000_0000, 1'b1});
`endif
        foreach (tbl[i]) begin
            modelAccess(tbl[i].addr, tbl[i].f, tbl[i].wd, expData, expIll);
            applyStimulus(tbl[i].addr, tbl[i].f, tbl[i].wd, rd, ill);
            checkOutput($sformatf("vec%0d rdata", i), 64'(rd), 64'(tbl[i].expData));
            checkOutput($sformatf("vec%0d illegal", i), 64'(ill), 64'(tbl[i].expIll));
        end

        modelCheck("instret rw", 12'hC02, RW, 32'd1);
        modelCheck("instret rs0", 12'hC02, RS, 32'd0);

        addrList = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'h800, 12'h801,
                     12'h802, 12'h803, 12'h804, 12'h80F, 12'h7FF, 12'hC03};
`ifndef CSR_MCOUNTER_EN
        addrList.push_back(12'hB00);
        addrList.push_back(12'hB80);
`endif
        for (int i = 0; i < 60; i++) begin
            f  = funct_t'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            modelCheck($sformatf("rand%0d", i), addrList[$urandom_range(0, addrList.size() - 1)], f, wd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Back-pressure: response held for 5 clks while a second request waits.
        modelAccess(12'h801, RW, 32'hDEAD_BEEF, expData, expIll);
        req_valid = 1'b1; req_addr = 12'h801; req_funct = RW; req_wdata = 32'hDEAD_BEEF;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_funct = NONE; req_wdata = 32'd0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d req_ready", i), 64'(req_ready), 64'd0);
            checkOutput($sformatf("stall%0d rdata", i), 64'(rsp_rdata), 64'(expData));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("release req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("queued rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("queued rdata", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);
        checkOutput("queued illegal", 64'(rsp_illegal), 64'd0);
        @(negedge clk);
        checkOutput("drained rsp_valid", 64'(rsp_valid), 64'd0);

`ifdef CSR_MCOUNTER_EN
        applyStimulus(12'hB00, RW, 32'hFFFF_FFFF, rd, ill);
        checkOutput("mcycle illegal", 64'(ill), 64'd0);
        applyStimulus(12'hB80, RW, 32'hFFFF_FFFF, rd, ill);
        checkOutput("mcycleh old", 64'(rd), 64'd0);
        repeat (2) @(negedge clk);
        applyStimulus(12'hC80, NONE, 32'd0, rd, ill);
        checkOutput("cycleh wrapped", 64'(rd), 64'd0);
        applyStimulus(12'hC00, NONE, 32'd0, rd, ill);
        checkOutput("cycle after wrap", 64'(rd), 64'd2);
`endif

        // Reset while a response is buffered.
        req_valid = 1'b1; req_addr = 12'h800; req_funct = NONE; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("pre-reset rsp_valid", 64'(rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("async rsp_rdata", 64'(rsp_rdata), 64'd0);
        foreach (scr[i]) scr[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(12'hC00, NONE, 32'd0, rd, ill);
        checkOutput("post-reset cycle", 64'(rd), 64'd0);
        modelCheck("post-reset time", 12'hC01, NONE, 32'd0);
        modelCheck("post-reset instret", 12'hC02, NONE, 32'd0);
        modelCheck("post-reset scratch", 12'h800, NONE, 32'd0);
        modelCheck("post-reset cycleh", 12'hC80, RS, 32'd0);
        while (edges < 80) @(negedge clk);
        applyStimulus(12'hC01, NONE, 32'd0, rd, ill);
        checkOutput("time at 80 clks", 64'(rd), 64'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
